// File: rtl/trg_tm_pkg.sv
// Shared types and constants for the trigger telemetry UART transmitter.
// Frame length follows TRG_TX_ODD_PARITY_EN (10 bits for 8N1, 11 bits with odd parity).
package trg_tm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdrH,
    StHdrL,
    StLen,
    StPayload,
    StCksum,
    StDone
  } tx_state_e;

  localparam logic [15:0] HdrWordDefault = 16'hEB90;

`ifdef TRG_TX_ODD_PARITY_EN
  localparam int unsigned FrameLen = 11;
`else
  localparam int unsigned FrameLen = 10;
`endif

  localparam int unsigned CksumWidth = 8;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/trg_uart_tx_byte.sv
// Single-byte UART serializer: baud counter, bit counter and shift register.
// Inserts an odd-parity bit after data bit 7 when TRG_TX_ODD_PARITY_EN is defined.
module trg_uart_tx_byte
  import trg_tm_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 347
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       ready_o,
  output logic       txd_o,
  output logic       start_o
);

  localparam logic [11:0] BaudMax = 12'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  BitMax  = 4'(FrameLen - 1);
  localparam int unsigned ShW     = FrameLen - 1;

  logic           active_q, active_d;
  logic [11:0]    baud_q, baud_d;
  logic [3:0]     bit_q, bit_d;
  logic [ShW-1:0] sh_q, sh_d;
  logic           txd_q, txd_d;
  logic           start_q, start_d;
  logic           bit_end, frame_end, accept;
  logic [ShW-1:0] frame_bits;

`ifdef TRG_TX_ODD_PARITY_EN
  assign frame_bits = {1'b1, odd_parity(byte_i), byte_i};
`else
  assign frame_bits = {1'b1, byte_i};
`endif

  // Ready on the last cycle of the stop bit so the next start bit follows with no gap.
  assign bit_end   = active_q && (baud_q == BaudMax);
  assign frame_end = bit_end && (bit_q == BitMax);
  assign ready_o   = !active_q || frame_end;
  assign accept    = load_i && ready_o;

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    txd_d    = txd_q;
    start_d  = 1'b0;
    if (accept) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
      sh_d     = frame_bits;
      txd_d    = 1'b0;
      start_d  = 1'b1;
    end else if (frame_end) begin
      active_d = 1'b0;
      baud_d   = '0;
      bit_d    = '0;
      txd_d    = 1'b1;
    end else if (bit_end) begin
      baud_d = '0;
      bit_d  = bit_q + 4'd1;
      txd_d  = sh_q[0];
      sh_d   = {1'b1, sh_q[ShW-1:1]};
    end else if (active_q) begin
      baud_d = baud_q + 12'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '1;
      txd_q    <= 1'b1;
      start_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      txd_q    <= txd_d;
      start_q  <= start_d;
    end
  end

  assign txd_o   = txd_q;
  assign start_o = start_q;

endmodule

// File: rtl/trg_tm_uart_tx.sv
// Telemetry packet transmitter: header, length, payload from FIFO, checksum over UART.
// Optional odd parity per byte via TRG_TX_ODD_PARITY_EN.
module trg_tm_uart_tx
  import trg_tm_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 347,
  parameter int unsigned PAYLOAD_LEN  = 16,
  parameter logic [15:0] HDR_WORD     = HdrWordDefault
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       send_req_i,
  input  logic       fifo_empty_i,
  output logic       fifo_rd_o,
  input  logic [7:0] fifo_data_i,
  output logic       txd_o,
  output logic       busy_o,
  output logic       pkt_done_o,
  output logic       underrun_o
);

  localparam logic [7:0] LenByte = 8'(PAYLOAD_LEN);
  localparam logic [7:0] PayMax  = 8'(PAYLOAD_LEN - 1);

  tx_state_e             state_q, state_d;
  logic [7:0]            pay_cnt_q, pay_cnt_d;
  logic [7:0]            next_byte_q, next_byte_d;
  logic [CksumWidth-1:0] cksum_q, cksum_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  underrun_q, underrun_d;

  logic       tx_load, tx_ready, tx_start;
  logic [7:0] tx_byte;
  logic       prefetch;

  trg_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .load_i (tx_load),
    .byte_i (tx_byte),
    .ready_o(tx_ready),
    .txd_o  (txd_o),
    .start_o(tx_start)
  );

  // Next payload byte is fetched at the start bit of the byte before it.
  assign prefetch = tx_start &&
                    ((state_q == StLen) || ((state_q == StPayload) && (pay_cnt_q != PayMax)));

  always_comb begin
    state_d     = state_q;
    pay_cnt_d   = pay_cnt_q;
    next_byte_d = next_byte_q;
    cksum_d     = cksum_q;
    rd_pend_d   = 1'b0;
    underrun_d  = underrun_q;
    tx_load     = 1'b0;
    tx_byte     = 8'h00;
    fifo_rd_o   = 1'b0;

    if (rd_pend_q) begin
      next_byte_d = fifo_data_i;
    end
    if (prefetch) begin
      if (fifo_empty_i) begin
        underrun_d  = 1'b1;
        next_byte_d = 8'h00;
      end else begin
        fifo_rd_o = 1'b1;
        rd_pend_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (send_req_i) begin
          tx_load    = 1'b1;
          tx_byte    = HDR_WORD[15:8];
          pay_cnt_d  = '0;
          cksum_d    = LenByte;
          underrun_d = 1'b0;
          state_d    = StHdrH;
        end
      end
      StHdrH: begin
        if (tx_ready) begin
          tx_load = 1'b1;
          tx_byte = HDR_WORD[7:0];
          state_d = StHdrL;
        end
      end
      StHdrL: begin
        if (tx_ready) begin
          tx_load = 1'b1;
          tx_byte = LenByte;
          state_d = StLen;
        end
      end
      StLen: begin
        if (tx_ready) begin
          tx_load = 1'b1;
          tx_byte = next_byte_q;
          cksum_d = cksum_q + next_byte_q;
          state_d = StPayload;
        end
      end
      StPayload: begin
        if (tx_ready) begin
          tx_load = 1'b1;
          if (pay_cnt_q == PayMax) begin
            tx_byte = cksum_q;
            state_d = StCksum;
          end else begin
            tx_byte   = next_byte_q;
            cksum_d   = cksum_q + next_byte_q;
            pay_cnt_d = pay_cnt_q + 8'd1;
          end
        end
      end
      StCksum: begin
        if (tx_ready) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      pay_cnt_q   <= '0;
      next_byte_q <= '0;
      cksum_q     <= '0;
      rd_pend_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pay_cnt_q   <= pay_cnt_d;
      next_byte_q <= next_byte_d;
      cksum_q     <= cksum_d;
      rd_pend_q   <= rd_pend_d;
      underrun_q  <= underrun_d;
    end
  end

  // The done cycle is neither busy nor idle, so a request landing on it is dropped.
  assign busy_o     = (state_q != StIdle) && (state_q != StDone);
  assign pkt_done_o = (state_q == StDone);
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_trg_tm_uart_tx.sv
// Scoreboard bench for trg_tm_uart_tx: expected bytes queued per packet, UART monitor decodes
// txd and compares. Honours TRG_TX_ODD_PARITY_EN for frame length and parity checks.
module tb_trg_tm_uart_tx;

  localparam int CPB = 4;
  localparam int PLEN = 4;
`ifdef TRG_TX_ODD_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       send_req = 1'b0;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [7:0] fifo_data = 8'h00;
  logic       txd, busy, pkt_done, underrun;

  logic [7:0] mem [16];
  logic [3:0] rd_ptr = 4'd0;
  logic [3:0] wr_ptr = 4'd0;
  int         rd_total = 0;

  logic [7:0] exp_q [$];
  int         n_tests = 0;
  int         n_fails = 0;

  always #5 clk = ~clk;

  trg_tm_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .PAYLOAD_LEN (PLEN)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .send_req_i  (send_req),
    .fifo_empty_i(fifo_empty),
    .fifo_rd_o   (fifo_rd),
    .fifo_data_i (fifo_data),
    .txd_o       (txd),
    .busy_o      (busy),
    .pkt_done_o  (pkt_done),
    .underrun_o  (underrun)
  );

  // FIFO model: read data valid the cycle after the strobe.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 4'd1;
      rd_total  <= rd_total + 1;
    end
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // UART monitor: samples mid-bit on negedges, aborts a frame if busy drops.
  initial begin : monitor
    forever begin
      logic [10:0] frm;
      logic        ok;
      logic [7:0]  e;
      @(negedge clk);
      if (txd === 1'b0) begin
        ok  = 1'b1;
        frm = '0;
        for (int k = 0; k < CPB / 2; k++) begin
          @(negedge clk);
          if (busy !== 1'b1) ok = 1'b0;
        end
        for (int b = 0; b < FL - 1 && ok; b++) begin
          for (int k = 0; k < CPB; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) ok = 1'b0;
          end
          frm[b] = txd;
        end
        if (ok) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fails++;
            $display("FAIL unexpected byte: got %0h, expected none", frm[7:0]);
          end else begin
            e = exp_q.pop_front();
            check("tx byte", {24'h0, frm[7:0]}, {24'h0, e});
          end
          check("stop bit", {31'h0, frm[FL-2]}, 32'h1);
`ifdef TRG_TX_ODD_PARITY_EN
          check("parity bit", {31'h0, frm[8]}, {31'h0, ~^frm[7:0]});
`endif
        end
      end
    end
  end

  task automatic run_pkt(input logic [31:0] fifo_bytes, input int n_avail,
                         input logic [31:0] exp_pl, input logic [7:0] exp_ck,
                         input logic exp_under, input bit mid_req, input int rst_at);
    int cyc;
    int rd0;
    wr_ptr = rd_ptr;
    for (int i = 0; i < n_avail; i++) begin
      mem[wr_ptr] = fifo_bytes[8*i +: 8];
      wr_ptr = wr_ptr + 4'd1;
    end
    exp_q.push_back(8'hEB);
    exp_q.push_back(8'h90);
    exp_q.push_back(8'(PLEN));
    for (int i = 0; i < PLEN; i++) exp_q.push_back(exp_pl[8*i +: 8]);
    exp_q.push_back(exp_ck);
    rd0 = rd_total;
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
    check("busy rise", {31'h0, busy}, 32'h1);
    check("underrun cleared on accept", {31'h0, underrun}, 32'h0);
    cyc = 0;
    while (pkt_done !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      send_req = (mid_req && cyc == 50);
      if (rst_at != 0 && cyc == rst_at) begin
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
        check("txd after reset", {31'h0, txd}, 32'h1);
        check("busy after reset", {31'h0, busy}, 32'h0);
        wr_ptr = rd_ptr;
        return;
      end
    end
    check("packet length", cyc, 8 * FL * CPB);
    check("fifo reads", rd_total - rd0, n_avail);
    check("underrun at done", {31'h0, underrun}, {31'h0, exp_under});
    check("all bytes seen", exp_q.size(), 0);
    if (mid_req) begin
      send_req = 1'b1;
      @(negedge clk);
      send_req = 1'b0;
      check("req on done ignored", {31'h0, busy}, 32'h0);
    end
    repeat (20) @(negedge clk);
    check("idle after packet", {31'h0, busy}, 32'h0);
    check("underrun sticky", {31'h0, underrun}, {31'h0, exp_under});
  endtask

  initial begin : timeout
    #500000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    check("reset txd", {31'h0, txd}, 32'h1);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset fifo_rd", {31'h0, fifo_rd}, 32'h0);
    check("reset pkt_done", {31'h0, pkt_done}, 32'h0);
    check("reset underrun", {31'h0, underrun}, 32'h0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // 01 02 03 04: 04+01+02+03+04 = 0E
    run_pkt(32'h04030201, 4, 32'h04030201, 8'h0E, 1'b0, 1'b0, 0);
    // FF x4: 04+3FC = 400 -> 00
    run_pkt(32'hFFFFFFFF, 4, 32'hFFFFFFFF, 8'h00, 1'b0, 1'b0, 0);
    // only 01 02 available: fillers 00, 04+01+02 = 07
    run_pkt(32'h00000201, 2, 32'h00000201, 8'h07, 1'b1, 1'b0, 0);
    // mid-packet and done-cycle requests ignored: 04+0A+0B+0C+0D = 32
    run_pkt(32'h0D0C0B0A, 4, 32'h0D0C0B0A, 8'h32, 1'b0, 1'b1, 0);
    // reset inside payload byte 0
    run_pkt(32'h04030201, 4, 32'h04030201, 8'h0E, 1'b0, 1'b0, 150);
    repeat (5) @(negedge clk);
    // clean frame after reset: 04+10+20+30+40 = A4
    run_pkt(32'h40302010, 4, 32'h40302010, 8'hA4, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/trg_tm_uart_tx.md
Name: trg_tm_uart_tx

Overview:
- Telemetry transmitter for the trigger board; the outbound counterpart of the command receive path (rxd sync + command distributor).
- On request, reads a fixed-length payload from the trigger status/science byte FIFO and frames it as header, length, payload and checksum.
- Serializes the frame as asynchronous UART (8N1, LSB first) on txd_o towards the electronics controller.

Parameters:
- CLKS_PER_BIT, 347, clock cycles per UART bit (40 MHz / 115200); legal range 4..4095.
- PAYLOAD_LEN, 16, payload bytes per packet; legal range 1..255.
- HDR_WORD, 16'hEB90, sync header, sent MSB byte first.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  synchronous reset, active-low
- send_req_i  in  1  single-cycle packet request
- fifo_empty_i  in  1  source FIFO empty flag
- fifo_rd_o  out  1  FIFO read strobe; data valid one cycle later
- fifo_data_i  in  8  FIFO read data
- txd_o  out  1  UART serial output, idle high
- busy_o  out  1  high from request acceptance until packet end
- pkt_done_o  out  1  one-cycle pulse after the final stop bit
- underrun_o  out  1  sticky; FIFO was empty when a payload byte was needed

Behaviour:
- Reset is synchronous, active-low, single clock clk_i.
- Reset values: txd_o=1, busy_o=0, fifo_rd_o=0, pkt_done_o=0, underrun_o=0; FSM returns to IDLE and bit/baud counters clear.
- Reset mid-packet aborts the frame; txd_o is 1 on the cycle after reset is sampled.
- FSM states: IDLE -> HDR_H -> HDR_L -> LEN -> PAYLOAD (xPAYLOAD_LEN) -> CKSUM -> DONE -> IDLE.
- IDLE: send_req_i=1 is accepted. busy_o=1 from the next cycle. The start bit of HDR_H begins on that same cycle.
- send_req_i while busy_o=1 is ignored (not queued).
- Byte frame: start bit (0), 8 data bits LSB first, stop bit (1). Every bit is exactly CLKS_PER_BIT cycles.
- Bytes are sent back-to-back with no idle gap. Total packet time = (PAYLOAD_LEN+4)*10*CLKS_PER_BIT cycles.
- LEN byte = PAYLOAD_LEN[7:0].
- Payload prefetch: fifo_rd_o pulses for one cycle on the first cycle of the preceding byte's start bit. The byte is latched into the next-byte register one cycle later.
- Underrun: if fifo_empty_i=1 at the prefetch point, fifo_rd_o is not asserted, byte 8'h00 is sent instead, and underrun_o is set. underrun_o stays set until the next accepted send_req_i.
- Checksum = (LEN + sum of transmitted payload bytes) mod 256, including any 00 fillers. Header bytes are excluded. An 8-bit accumulator wraps silently.
- DONE: pkt_done_o=1 for one cycle on the first cycle after the CKSUM stop bit ends. busy_o drops on that same cycle and the FSM enters IDLE.
- A send_req_i on the pkt_done_o cycle is ignored; requests are accepted only from the following cycle.

Optional Feature:
- Macro: TRG_TX_ODD_PARITY_EN.
- Defined: an odd-parity bit (the data bits plus parity contain an odd number of 1s) is inserted after data bit 7. The frame becomes 11 bits; packet time = (PAYLOAD_LEN+4)*11*CLKS_PER_BIT. Prefetch timing is unchanged.
- Undefined: plain 8N1 as above.

Decomposition:
- Shared package trg_tm_pkg holds the FSM state enum, HDR_WORD default, the UART frame-length constant (10 or 11, macro-dependent) and the checksum width.
- Sub-module trg_uart_tx_byte contains the baud counter, bit counter and shift register.
- trg_uart_tx_byte interface: load/ready handshake, byte_i, txd_o, and a start_o pulse used as the prefetch point.
- The top level contains the packet FSM, checksum accumulator and FIFO interface.

Test Plan (simulation: CLKS_PER_BIT=4, PAYLOAD_LEN=4):
- FIFO holds 01 02 03 04; pulse send_req_i -> decoded stream EB 90 04 01 02 03 04 0E; exactly 4 fifo_rd_o pulses; pkt_done_o 320 cycles after busy_o rises; underrun_o=0.
- FIFO holds FF FF FF FF -> checksum byte 00 (0x400 wraps to 00).
- FIFO holds only 01 02 -> payload 01 02 00 00, checksum 07, underrun_o=1 until the next accepted request.
- send_req_i pulsed 50 cycles into a packet -> no second packet, frame unaffected; a new request after pkt_done_o yields a second correct packet.
- rstn_i=0 for one cycle mid-payload -> txd_o=1 and busy_o=0 the next cycle; a subsequent request sends a clean full frame.
- With TRG_TX_ODD_PARITY_EN defined, byte 01 -> bits 0,1,0,0,0,0,0,0,0, parity 0, stop 1; packet length 352 cycles.
